// File: rtl/l2_mem_fill_ctrl.sv
// rtl/l2_mem_fill_ctrl.sv - L2 miss-fill controller: LOAD_MEM request, ack wait with timeout/retry, one-cycle cache fill
// Single outstanding miss; all outputs are registered in the FSM block.
module l2_mem_fill_ctrl #(
  parameter logic [7:0] LOAD_MEM_TYPE     = 8'h13,
  parameter logic [7:0] LOAD_MEM_ACK_TYPE = 8'h18,
  parameter int         TIMEOUT_CYCLES    = 255,
  parameter int         MAX_RETRY         = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_miss_valid,
  output logic        o_miss_ready,
  input  logic [25:0] i_miss_tag,
  input  logic [5:0]  i_miss_source,
  output logic        o_msg2_valid,
  input  logic        i_msg2_ready,
  output logic [7:0]  o_msg2_type,
  output logic [25:0] o_msg2_tag,
  input  logic        i_msg3_valid,
  output logic        o_msg3_ready,
  input  logic [7:0]  i_msg3_type,
  input  logic [25:0] i_msg3_tag,
  input  logic [63:0] i_msg3_data,
  output logic        o_fill_valid,
  output logic [25:0] o_fill_tag,
  output logic [63:0] o_fill_data,
  output logic [1:0]  o_fill_vd,
  output logic [1:0]  o_fill_msg_state,
  output logic [5:0]  o_fill_source,
  output logic        o_ack_mismatch,
  output logic        o_fill_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_FILL} state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t      r_state;
  logic [25:0] r_tag;
  logic [5:0]  r_source;
  logic [7:0]  r_tmo_cnt;
  logic [3:0]  r_retry_cnt;

  logic        r_miss_ready;
  logic        r_msg2_valid;
  logic [7:0]  r_msg2_type;
  logic [25:0] r_msg2_tag;
  logic        r_msg3_ready;
  logic        r_fill_valid;
  logic [25:0] r_fill_tag;
  logic [63:0] r_fill_data;
  logic [1:0]  r_fill_vd;
  logic [1:0]  r_fill_msg_state;
  logic [5:0]  r_fill_source;
  logic        r_ack_mismatch;
  logic        r_fill_err;

  logic w_beat;
  logic w_match;
  logic w_timeout;

  // r_msg3_ready is only ever high in WAIT_ACK, so a beat cannot be taken elsewhere.
  assign w_beat    = i_msg3_valid & r_msg3_ready;
  assign w_match   = w_beat && (i_msg3_type == LOAD_MEM_ACK_TYPE) && (i_msg3_tag == r_tag);
  assign w_timeout = (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_tag            <= '0;
      r_source         <= '0;
      r_tmo_cnt        <= '0;
      r_retry_cnt      <= '0;
      r_miss_ready     <= 1'b1;
      r_msg2_valid     <= 1'b0;
      r_msg2_type      <= '0;
      r_msg2_tag       <= '0;
      r_msg3_ready     <= 1'b0;
      r_fill_valid     <= 1'b0;
      r_fill_tag       <= '0;
      r_fill_data      <= '0;
      r_fill_vd        <= '0;
      r_fill_msg_state <= '0;
      r_fill_source    <= '0;
      r_ack_mismatch   <= 1'b0;
      r_fill_err       <= 1'b0;
    end else begin
      r_fill_valid     <= 1'b0;
      r_fill_tag       <= '0;
      r_fill_data      <= '0;
      r_fill_vd        <= '0;
      r_fill_msg_state <= '0;
      r_fill_source    <= '0;
      r_ack_mismatch   <= 1'b0;
      r_fill_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_miss_valid) begin
            r_tag        <= i_miss_tag;
            r_source     <= i_miss_source;
            r_retry_cnt  <= '0;
            r_state      <= S_REQ;
            r_miss_ready <= 1'b0;
            r_msg2_valid <= 1'b1;
            r_msg2_type  <= LOAD_MEM_TYPE;
            r_msg2_tag   <= i_miss_tag;
          end
        end
        S_REQ: begin
          if (i_msg2_ready) begin
            r_state      <= S_WAIT_ACK;
            r_tmo_cnt    <= '0;
            r_msg2_valid <= 1'b0;
            r_msg2_type  <= '0;
            r_msg2_tag   <= '0;
            r_msg3_ready <= 1'b1;
          end
        end
        S_WAIT_ACK: begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
          if (w_match) begin
            r_state          <= S_FILL;
            r_msg3_ready     <= 1'b0;
            r_fill_valid     <= 1'b1;
            r_fill_tag       <= r_tag;
            r_fill_data      <= i_msg3_data;
            r_fill_vd        <= 2'b10;
            r_fill_msg_state <= 2'b10;
            r_fill_source    <= r_source;
          end else begin
            r_ack_mismatch <= w_beat;
            if (w_timeout) begin
              r_msg3_ready <= 1'b0;
              if (r_retry_cnt < RETRY_MAX) begin
                r_retry_cnt  <= r_retry_cnt + 4'd1;
                r_state      <= S_REQ;
                r_msg2_valid <= 1'b1;
                r_msg2_type  <= LOAD_MEM_TYPE;
                r_msg2_tag   <= r_tag;
              end else begin
                r_fill_err   <= 1'b1;
                r_state      <= S_IDLE;
                r_miss_ready <= 1'b1;
              end
            end
          end
        end
        S_FILL: begin
          r_state      <= S_IDLE;
          r_miss_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_miss_ready     = r_miss_ready;
  assign o_msg2_valid     = r_msg2_valid;
  assign o_msg2_type      = r_msg2_type;
  assign o_msg2_tag       = r_msg2_tag;
  assign o_msg3_ready     = r_msg3_ready;
  assign o_fill_valid     = r_fill_valid;
  assign o_fill_tag       = r_fill_tag;
  assign o_fill_data      = r_fill_data;
  assign o_fill_vd        = r_fill_vd;
  assign o_fill_msg_state = r_fill_msg_state;
  assign o_fill_source    = r_fill_source;
  assign o_ack_mismatch   = r_ack_mismatch;
  assign o_fill_err       = r_fill_err;

endmodule

// File: tb/tb_l2_mem_fill_ctrl.sv
// tb/tb_l2_mem_fill_ctrl.sv - bench for l2_mem_fill_ctrl: directed scenario table, reset cases, randomized misses vs transaction model
module tb_l2_mem_fill_ctrl;
  localparam int T  = 4;
  localparam int MR = 2;
  localparam logic [7:0] REQ_T = 8'h13;
  localparam logic [7:0] ACK_T = 8'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss_valid, o_miss_ready;
  logic [25:0] i_miss_tag;
  logic [5:0]  i_miss_source;
  logic        o_msg2_valid, i_msg2_ready;
  logic [7:0]  o_msg2_type;
  logic [25:0] o_msg2_tag;
  logic        i_msg3_valid, o_msg3_ready;
  logic [7:0]  i_msg3_type;
  logic [25:0] i_msg3_tag;
  logic [63:0] i_msg3_data;
  logic        o_fill_valid;
  logic [25:0] o_fill_tag;
  logic [63:0] o_fill_data;
  logic [1:0]  o_fill_vd, o_fill_msg_state;
  logic [5:0]  o_fill_source;
  logic        o_ack_mismatch, o_fill_err;

  always #5 clk = ~clk;

  l2_mem_fill_ctrl #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready),
    .i_miss_tag(i_miss_tag), .i_miss_source(i_miss_source),
    .o_msg2_valid(o_msg2_valid), .i_msg2_ready(i_msg2_ready),
    .o_msg2_type(o_msg2_type), .o_msg2_tag(o_msg2_tag),
    .i_msg3_valid(i_msg3_valid), .o_msg3_ready(o_msg3_ready),
    .i_msg3_type(i_msg3_type), .i_msg3_tag(i_msg3_tag), .i_msg3_data(i_msg3_data),
    .o_fill_valid(o_fill_valid), .o_fill_tag(o_fill_tag), .o_fill_data(o_fill_data),
    .o_fill_vd(o_fill_vd), .o_fill_msg_state(o_fill_msg_state), .o_fill_source(o_fill_source),
    .o_ack_mismatch(o_ack_mismatch), .o_fill_err(o_fill_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_hs = 0, n_fill = 0, n_err = 0, n_mm = 0, fill_cyc = 0;
  logic [25:0] f_tag;
  logic [63:0] f_data;
  logic [5:0]  f_src;
  logic [1:0]  f_vd, f_ms;

  always @(negedge clk) begin
    if (o_msg2_valid && i_msg2_ready) n_hs++;
    if (o_ack_mismatch) n_mm++;
    if (o_fill_err) n_err++;
    if (o_fill_valid) begin
      n_fill++;
      fill_cyc = cyc;
      f_tag = o_fill_tag; f_data = o_fill_data; f_src = o_fill_source;
      f_vd = o_fill_vd; f_ms = o_fill_msg_state;
    end else begin
      chk("fill_fields_zero", 64'((|o_fill_tag) | (|o_fill_data) | (|o_fill_vd) |
                                  (|o_fill_msg_state) | (|o_fill_source)), 64'd0);
    end
  end

  // ack[a]: WAIT_ACK cycle on which attempt a sees the matching ack; T or more = never.
  typedef struct {
    logic [25:0]     tag;
    logic [5:0]      src;
    logic [63:0]     data;
    int              d;
    logic [2:0][2:0] ack;
    logic [3:0]      junk;
    bit              exp_fill;
    int              exp_hs;
    int              exp_mm;
    int              exp_lat;
  } scen_t;

  function automatic scen_t model(input scen_t s);
    scen_t r = s;
    int k, lim;
    r.exp_fill = 0; r.exp_hs = 0; r.exp_mm = 0; r.exp_lat = 0;
    for (int a = 0; a <= MR; a++) begin
      r.exp_hs++;
      k   = int'(s.ack[a]);
      lim = (k < T) ? k : T;
      for (int j = 0; j < lim; j++) if (s.junk[j]) r.exp_mm++;
      if (k < T) begin
        r.exp_fill = 1;
        r.exp_lat += s.d + 3 + k;
        return r;
      end
      r.exp_lat += s.d + 1 + T;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_miss_ready"}, 64'(o_miss_ready), 64'd1);
    chk({name, "_others_zero"}, 64'(o_msg2_valid | (|o_msg2_type) | (|o_msg2_tag) | o_msg3_ready |
                                   o_fill_valid | o_ack_mismatch | o_fill_err), 64'd0);
  endtask

  task automatic run(input scen_t s, input string name);
    int hs0, fill0, err0, mm0, acc, k, n;
    n = 0;
    while (!o_miss_ready && n < 40) begin step(); n++; end
    chk({name, "_idle_wait"}, 64'(o_miss_ready), 64'd1);
    hs0 = n_hs; fill0 = n_fill; err0 = n_err; mm0 = n_mm;
    i_miss_tag = s.tag; i_miss_source = s.src; i_miss_valid = 1'b1;
    acc = cyc;
    step();
    i_miss_valid = 1'b0; i_miss_tag = ~s.tag; i_miss_source = ~s.src;
    chk({name, "_miss_ready_busy"}, 64'(o_miss_ready), 64'd0);
    for (int a = 0; a <= MR; a++) begin
      n = 0;
      while (!o_msg2_valid && n < 20) begin step(); n++; end
      chk({name, "_req_seen"}, 64'(o_msg2_valid), 64'd1);
      for (int i = 0; i < s.d; i++) begin
        i_msg2_ready = 1'b0;
        i_msg3_valid = 1'b1; i_msg3_type = ACK_T; i_msg3_tag = s.tag; i_msg3_data = ~s.data;
        chk({name, "_req_hold"}, {o_msg2_valid, o_msg3_ready, o_miss_ready, o_msg2_type, o_msg2_tag},
            {1'b1, 1'b0, 1'b0, REQ_T, s.tag});
        step();
      end
      i_msg3_valid = 1'b0;
      chk({name, "_req"}, {o_msg2_valid, o_msg3_ready, o_msg2_type, o_msg2_tag}, {1'b1, 1'b0, REQ_T, s.tag});
      i_msg2_ready = 1'b1;
      step();
      i_msg2_ready = 1'b0;
      k = int'(s.ack[a]);
      for (int j = 0; j < T; j++) begin
        chk({name, "_wait"}, {o_msg3_ready, o_msg2_valid}, 2'b10);
        if (j == k) begin
          i_msg3_valid = 1'b1; i_msg3_type = ACK_T; i_msg3_tag = s.tag; i_msg3_data = s.data;
        end else if (s.junk[j]) begin
          i_msg3_valid = 1'b1; i_msg3_data = $urandom();
          i_msg3_type = (j % 2 == 0) ? ACK_T : REQ_T;
          i_msg3_tag  = (j % 2 == 0) ? (s.tag ^ 26'h1) : s.tag;
        end
        step();
        i_msg3_valid = 1'b0;
        if (j == k) break;
      end
      if (k < T) break;
    end
    step(); step();
    chk({name, "_handshakes"}, 64'(n_hs - hs0), 64'(s.exp_hs));
    chk({name, "_mismatch_pulses"}, 64'(n_mm - mm0), 64'(s.exp_mm));
    chk({name, "_fill_count"}, 64'(n_fill - fill0), 64'(s.exp_fill));
    chk({name, "_err_count"}, 64'(n_err - err0), 64'(!s.exp_fill));
    if (s.exp_fill) begin
      chk({name, "_fill_tag"}, 64'(f_tag), 64'(s.tag));
      chk({name, "_fill_data"}, f_data, s.data);
      chk({name, "_fill_src_vd_ms"}, {f_src, f_vd, f_ms}, {s.src, 2'b10, 2'b10});
      chk({name, "_latency"}, 64'(fill_cyc - acc), 64'(s.exp_lat));
    end
    chk({name, "_miss_ready_after"}, 64'(o_miss_ready), 64'd1);
  endtask

  scen_t tbl[7];
  scen_t s;

  initial begin
    // {tag, src, data, req delay, ack per attempt (4=none), junk mask, fill, handshakes, mismatches, latency}
    tbl[0] = '{26'h0ABCDEF, 6'd5,  64'h1122334455667788, 0, {3'd4, 3'd4, 3'd0}, 4'b0000, 1, 1, 0, 3};
    tbl[1] = '{26'h1234567, 6'd9,  64'hDEADBEEFCAFEF00D, 5, {3'd4, 3'd4, 3'd0}, 4'b0000, 1, 1, 0, 8};
    tbl[2] = '{26'h0000000, 6'd17, 64'h0F0F0F0F0F0F0F0F, 0, {3'd4, 3'd4, 3'd2}, 4'b0011, 1, 1, 2, 5};
    tbl[3] = '{26'h3FFFFFF, 6'd63, 64'hFFFFFFFFFFFFFFFF, 0, {3'd4, 3'd4, 3'd4}, 4'b0000, 0, 3, 0, 0};
    tbl[4] = '{26'h2AAAAAA, 6'd1,  64'h8000000000000001, 0, {3'd4, 3'd4, 3'd3}, 4'b0000, 1, 1, 0, 6};
    tbl[5] = '{26'h1555555, 6'd33, 64'h0123456789ABCDEF, 0, {3'd4, 3'd1, 3'd4}, 4'b0001, 1, 2, 2, 9};
    tbl[6] = '{26'h00000FF, 6'd42, 64'hA5A5A5A55A5A5A5A, 2, {3'd3, 3'd4, 3'd4}, 4'b1000, 1, 3, 2, 22};

    rst = 1'b1; i_miss_valid = 1'b0; i_miss_tag = '0; i_miss_source = '0; i_msg2_ready = 1'b0;
    i_msg3_valid = 1'b0; i_msg3_type = '0; i_msg3_tag = '0; i_msg3_data = '0;
    step(); step();
    chk_idle("reset");
    rst = 1'b0;
    step();
    chk_idle("post_reset");

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("dir%0d", i));

    // Reset while waiting for the ack, then a fresh miss must fill normally.
    i_miss_tag = 26'h0055AA5; i_miss_source = 6'd7; i_miss_valid = 1'b1;
    step();
    i_miss_valid = 1'b0; i_msg2_ready = 1'b1;
    step();
    i_msg2_ready = 1'b0;
    step();
    chk("rst_wait_msg3_ready", 64'(o_msg3_ready), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst_in_wait");
    run(tbl[0], "after_rst");

    for (int i = 0; i < 40; i++) begin
      s.tag  = 26'($urandom());
      s.src  = 6'($urandom());
      s.data = {$urandom(), $urandom()};
      s.d    = int'($urandom_range(0, 3));
      for (int a = 0; a < 3; a++) s.ack[a] = 3'($urandom_range(0, 4));
      s.junk = 4'($urandom());
      s = model(s);
      run(s, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
